vga_fill_ctrl: RTL

VGA_FILL_CTRL -- requirements
Module: vga_fill_ctrl

---
 rtl/vga_pkg.sv | 31 +++
 rtl/vga_fill_ctrl_if.sv | 36 +++
 rtl/vga_raster_cnt.sv | 48 ++++
 rtl/vga_fill_ctrl.sv | 126 ++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared widths, frame defaults, FSM states and min/max helpers for the fill controller
package vga_pkg;

  localparam int W_DEF = 336;
  localparam int H_DEF = 210;
  localparam int XW    = 10;
  localparam int YW    = 9;
  localparam int CW    = 3;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_t;

  function automatic logic [XW-1:0] min_x(input logic [XW-1:0] a, input logic [XW-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [XW-1:0] max_x(input logic [XW-1:0] a, input logic [XW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [YW-1:0] min_y(input logic [YW-1:0] a, input logic [YW-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [YW-1:0] max_y(input logic [YW-1:0] a, input logic [YW-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/vga_fill_ctrl_if.sv
// rtl/vga_fill_ctrl_if.sv - fill request, direct pixel and plot port bundle
interface vga_fill_ctrl_if;
  import vga_pkg::*;

  logic          start;
  logic [XW-1:0] x0;
  logic [XW-1:0] x1;
  logic [YW-1:0] y0;
  logic [YW-1:0] y1;
  logic [CW-1:0] fill_color;

  logic          pix_req;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic [CW-1:0] pix_color;

  logic          busy;
  logic          done;
  logic [XW-1:0] vga_x;
  logic [YW-1:0] vga_y;
  logic [CW-1:0] vga_color;
  logic          vga_plot;

  modport master (
    output start, x0, x1, y0, y1, fill_color,
    output pix_req, pix_x, pix_y, pix_color,
    input  busy, done, vga_x, vga_y, vga_color, vga_plot
  );

  modport slave (
    input  start, x0, x1, y0, y1, fill_color,
    input  pix_req, pix_x, pix_y, pix_color,
    output busy, done, vga_x, vga_y, vga_color, vga_plot
  );

endinterface

// File: rtl/vga_raster_cnt.sv
// rtl/vga_raster_cnt.sv - raster cursor over a latched rectangle with load, step and last flag
module vga_raster_cnt
  import vga_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic          step,
  input  logic [XW-1:0] xl,
  input  logic [XW-1:0] xh,
  input  logic [YW-1:0] yl,
  input  logic [YW-1:0] yh,
  output logic [XW-1:0] cx,
  output logic [YW-1:0] cy,
  output logic          last
);

  logic [XW-1:0] xl_q;
  logic [XW-1:0] xh_q;
  logic [YW-1:0] yh_q;

  // Latch bounds on load, then walk columns first and wrap to the next row at xh.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      xl_q <= '0;
      xh_q <= '0;
      yh_q <= '0;
      cx   <= '0;
      cy   <= '0;
    end else if (load) begin
      xl_q <= xl;
      xh_q <= xh;
      yh_q <= yh;
      cx   <= xl;
      cy   <= yl;
    end else if (step) begin
      if (cx == xh_q) begin
        cx <= xl_q;
        cy <= cy + 1'b1;
      end else begin
        cx <= cx + 1'b1;
      end
    end
  end

  assign last = (cx == xh_q) && (cy == yh_q);

endmodule

// File: rtl/vga_fill_ctrl.sv
// rtl/vga_fill_ctrl.sv - rectangle fill scheduler with priority direct pixel writes to the frame store
module vga_fill_ctrl
  import vga_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int H = H_DEF
) (
  input  logic            clk,
  input  logic            reset_n,
  vga_fill_ctrl_if.slave  bus
);

  localparam logic [XW-1:0] X_MAX = XW'(W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(H - 1);

  state_t        state;
  logic          busy_q;
  logic          done_q;
  logic          plot_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [CW-1:0] c_q;
  logic [CW-1:0] fill_c_q;

  logic [XW-1:0] xl_c;
  logic [XW-1:0] xmax_c;
  logic [XW-1:0] xh_c;
  logic [YW-1:0] yl_c;
  logic [YW-1:0] ymax_c;
  logic [YW-1:0] yh_c;
  logic          fill_empty;
  logic          pix_ok;
  logic          load;
  logic          step;

  logic [XW-1:0] cx;
  logic [YW-1:0] cy;
  logic          last;

  // Normalise corners, clip the high edges to the frame and decide load/step.
  always_comb begin
    xl_c       = min_x(bus.x0, bus.x1);
    xmax_c     = max_x(bus.x0, bus.x1);
    xh_c       = (xmax_c > X_MAX) ? X_MAX : xmax_c;
    yl_c       = min_y(bus.y0, bus.y1);
    ymax_c     = max_y(bus.y0, bus.y1);
    yh_c       = (ymax_c > Y_MAX) ? Y_MAX : ymax_c;
    fill_empty = (xl_c > X_MAX) || (yl_c > Y_MAX);
    pix_ok     = (bus.pix_x <= X_MAX) && (bus.pix_y <= Y_MAX);
    load       = (state == S_IDLE) && bus.start && !fill_empty;
    step       = (state == S_FILL) && !bus.pix_req;
  end

  vga_raster_cnt u_cursor (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .step    (step),
    .xl      (xl_c),
    .xh      (xh_c),
    .yl      (yl_c),
    .yh      (yh_c),
    .cx      (cx),
    .cy      (cy),
    .last    (last)
  );

  // Scheduler FSM: a direct pixel always wins the plot slot; otherwise the cursor pixel goes out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      plot_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      c_q      <= '0;
      fill_c_q <= '0;
    end else begin
      done_q <= 1'b0;
      plot_q <= 1'b0;
      // Out-of-frame direct pixels are dropped but still occupy the slot.
      if (bus.pix_req && pix_ok) begin
        plot_q <= 1'b1;
        x_q    <= bus.pix_x;
        y_q    <= bus.pix_y;
        c_q    <= bus.pix_color;
      end
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            if (fill_empty) begin
              done_q <= 1'b1;
            end else begin
              state    <= S_FILL;
              busy_q   <= 1'b1;
              fill_c_q <= bus.fill_color;
            end
          end
        end
        S_FILL: begin
          if (!bus.pix_req) begin
            plot_q <= 1'b1;
            x_q    <= cx;
            y_q    <= cy;
            c_q    <= fill_c_q;
            if (last) begin
              state  <= S_IDLE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.vga_plot  = plot_q;
  assign bus.vga_x     = x_q;
  assign bus.vga_y     = y_q;
  assign bus.vga_color = c_q;

endmodule
